// File: rtl/i2c_fifo_tx_master.sv
// Write-only I2C master: START, address+W, then drains FIFO bytes until empty or NACK, then STOP.
// Optional build macro I2C_TX_NACK_FLUSH_EN: after a data NACK, pop and discard the rest of the FIFO.
module i2c_fifo_tx_master #(
   parameter int CLK_DIV  = 4,
   parameter int DATASIZE = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [6:0]          slave_addr_i,
   input  logic [DATASIZE-1:0] rdata_i,
   input  logic                rempty_i,
   output logic                rinc_o,
   input  logic                sda_i,
   output logic                scl_o,
   output logic                sda_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                nack_o
);
   localparam int QW = $clog2(CLK_DIV);
   localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

`ifdef I2C_TX_NACK_FLUSH_EN
   typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP, FLUSH} state_t;
`else
   typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP} state_t;
`endif

   state_t              state_reg, state_next;
   logic [QW-1:0]       qcnt_reg;
   logic [1:0]          quarter_reg;
   logic [2:0]          bit_cnt_reg;
   logic [DATASIZE-1:0] shift_reg;
   logic                ack_reg;
   logic                nack_reg;
   logic                done_reg;
   logic                tick, bit_end, timed, accept, flush_go;
`ifdef I2C_TX_NACK_FLUSH_EN
   logic                flush_pend_reg;
   logic                flush_ph_reg;
`endif

   assign tick    = (qcnt_reg == QMAX);
   assign bit_end = tick && (quarter_reg == 2'd3);
   assign busy_o  = (state_reg != IDLE) || done_reg;
   assign accept  = start_i && !busy_o;
   assign done_o  = done_reg;
   assign nack_o  = nack_reg;
`ifdef I2C_TX_NACK_FLUSH_EN
   assign flush_go = flush_pend_reg;
`else
   assign flush_go = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      scl_o      = 1'b1;
      sda_o      = 1'b1;
      rinc_o     = 1'b0;
      timed      = 1'b1;
      case (state_reg)
         IDLE: begin
            timed = 1'b0;
            if (accept) state_next = START;
         end
         START: begin
            scl_o = (quarter_reg != 2'd3);
            sda_o = (quarter_reg == 2'd0);
            if (bit_end) state_next = ADDR;
         end
         ADDR, DATA: begin
            scl_o = (quarter_reg == 2'd1) || (quarter_reg == 2'd2);
            sda_o = shift_reg[DATASIZE-1];
            if (bit_end && bit_cnt_reg == 3'd0)
               state_next = (state_reg == ADDR) ? ADDR_ACK : DATA_ACK;
         end
         ADDR_ACK, DATA_ACK: begin
            scl_o = (quarter_reg == 2'd1) || (quarter_reg == 2'd2);
            if (bit_end) state_next = ack_reg ? STOP : LOAD;
         end
         LOAD: begin
            timed  = 1'b0;
            scl_o  = 1'b0;
            rinc_o = !rempty_i;
            state_next = rempty_i ? STOP : DATA;
         end
         STOP: begin
            scl_o = (quarter_reg != 2'd0);
            sda_o = quarter_reg[1];
            if (bit_end) begin
`ifdef I2C_TX_NACK_FLUSH_EN
               state_next = flush_go ? FLUSH : IDLE;
`else
               state_next = IDLE;
`endif
            end
         end
`ifdef I2C_TX_NACK_FLUSH_EN
         FLUSH: begin
            // Every other cycle, so the registered empty flag catches up before the next pop.
            timed  = 1'b0;
            rinc_o = !rempty_i && !flush_ph_reg;
            if (rempty_i) state_next = IDLE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         qcnt_reg    <= '0;
         quarter_reg <= 2'd0;
         bit_cnt_reg <= 3'd0;
         shift_reg   <= '0;
         ack_reg     <= 1'b0;
         nack_reg    <= 1'b0;
         done_reg    <= 1'b0;
`ifdef I2C_TX_NACK_FLUSH_EN
         flush_pend_reg <= 1'b0;
         flush_ph_reg   <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         if (!timed) begin
            qcnt_reg    <= '0;
            quarter_reg <= 2'd0;
         end else if (tick) begin
            qcnt_reg    <= '0;
            quarter_reg <= quarter_reg + 2'd1;
         end else begin
            qcnt_reg <= qcnt_reg + QW'(1);
         end

         if (accept) begin
            shift_reg   <= {slave_addr_i, 1'b0};
            bit_cnt_reg <= 3'd7;
            nack_reg    <= 1'b0;
`ifdef I2C_TX_NACK_FLUSH_EN
            flush_pend_reg <= 1'b0;
`endif
         end

         // Bit counter wraps 0 -> 7 on the last bit, ready for the next byte.
         if ((state_reg == ADDR || state_reg == DATA) && bit_end) begin
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg - 3'd1;
         end

         if (state_reg == LOAD && !rempty_i) begin
            shift_reg   <= rdata_i;
            bit_cnt_reg <= 3'd7;
         end

         if (state_reg == ADDR_ACK || state_reg == DATA_ACK) begin
            if (quarter_reg == 2'd2 && qcnt_reg == '0) ack_reg <= sda_i;
            if (bit_end && ack_reg) begin
               nack_reg <= 1'b1;
`ifdef I2C_TX_NACK_FLUSH_EN
               if (state_reg == DATA_ACK) flush_pend_reg <= 1'b1;
`endif
            end
         end

         if (state_reg == STOP && bit_end && !flush_go) done_reg <= 1'b1;
`ifdef I2C_TX_NACK_FLUSH_EN
         flush_ph_reg <= (state_reg == FLUSH) ? !flush_ph_reg : 1'b0;
         if (state_reg == FLUSH && rempty_i) begin
            done_reg       <= 1'b1;
            flush_pend_reg <= 1'b0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_i2c_fifo_tx_master.sv
// Scoreboard bench for i2c_fifo_tx_master: FIFO model, bus decoder/slave, done/latency monitor.
module tb_i2c_fifo_tx_master;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] slave_addr = 7'h00;
   logic [7:0] rdata = 8'h00;
   logic       rempty = 1'b1;
   logic       rinc, scl, sda, busy, done, nack;
   logic       pull = 1'b0;
   logic       bus_sda;

   assign bus_sda = sda & ~pull;

   i2c_fifo_tx_master #(.CLK_DIV(4), .DATASIZE(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .slave_addr_i(slave_addr),
      .rdata_i(rdata), .rempty_i(rempty), .rinc_o(rinc), .sda_i(bus_sda),
      .scl_o(scl), .sda_o(sda), .busy_o(busy), .done_o(done), .nack_o(nack));

   always #5 clk = ~clk;

   typedef struct {int lat; int nk;} done_exp_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         t0 = 0;
   int         pops = 0;
   int         nack_at = -1;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_bytes[$];
   done_exp_t  exp_done[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // FIFO read side: registered empty flag and head word, updated one clock after a pop.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rinc) begin
         chk("pop_while_empty", int'(rempty), 0);
         if (fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
         end
      end
      rempty <= (fifo_q.size() == 0);
      rdata  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   end

   // Bus decoder, ACKing slave and done monitor.
   int         bitcnt = 0;
   int         frame_idx = 0;
   logic [7:0] cur = 8'h00;
   logic       prev_scl = 1'b1;
   logic       prev_sda = 1'b1;
   always @(negedge clk) begin
      if (!rst_n) begin
         bitcnt    = 0;
         frame_idx = 0;
         pull      = 1'b0;
      end else begin
         if (prev_scl && scl && prev_sda && !bus_sda) begin
            bitcnt    = 0;
            frame_idx = 0;
         end else if (!prev_scl && scl) begin
            if (bitcnt < 8) cur = {cur[6:0], bus_sda};
            bitcnt++;
            if (bitcnt == 8) begin
               frame_idx++;
               if (exp_bytes.size() == 0) chk("unexpected_bus_byte", int'(cur), -1);
               else chk("bus_byte", int'(cur), int'(exp_bytes.pop_front()));
            end else if (bitcnt == 9) begin
               bitcnt = 0;
            end
         end else if (prev_scl && !scl) begin
            pull = (bitcnt == 8) && (frame_idx - 1 != nack_at);
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               done_exp_t e;
               e = exp_done.pop_front();
               $display("txn: done latency %0d nack %0d pops %0d", cyc - t0, nack, pops);
               chk("done_latency", cyc - t0, e.lat);
               chk("done_nack", int'(nack), e.nk);
               chk("busy_at_done", int'(busy), 1);
            end
         end
      end
      prev_scl = scl;
      prev_sda = bus_sda;
   end

   task automatic preload(input logic [7:0] b[$]);
      foreach (b[i]) fifo_q.push_back(b[i]);
      repeat (2) @(negedge clk);
   endtask

   task automatic start_txn(input logic [6:0] a);
      @(negedge clk);
      slave_addr = a;
      start      = 1'b1;
      t0         = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_done.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         chk("done_timeout", 1, 0);
         exp_done.delete();
      end
      repeat (3) @(negedge clk);
      chk("bytes_left_unseen", exp_bytes.size(), 0);
      exp_bytes.delete();
   endtask

   initial begin
      logic [7:0] pl[$];
      #12;
      chk("rst_scl", int'(scl), 1);
      chk("rst_sda", int'(sda), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_nack", int'(nack), 0);
      chk("rst_rinc", int'(rinc), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Two bytes, all ACKed; a start pulse mid-transaction must be ignored.
      pl = '{8'hA5, 8'h3C};
      preload(pl);
      pops = 0; nack_at = -1;
      exp_bytes = '{8'hA0, 8'hA5, 8'h3C};
      exp_done.push_back('{468, 0});
      start_txn(7'h50);
      repeat (50) @(negedge clk);
      chk("busy_mid_txn", int'(busy), 1);
      slave_addr = 7'h7F;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("pops_two_bytes", pops, 2);
      chk("busy_after", int'(busy), 0);

      // Empty FIFO: address only.
      pops = 0; nack_at = -1;
      exp_bytes = '{8'h24};
      exp_done.push_back('{178, 0});
      start_txn(7'h12);
      wait_done();
      chk("pops_empty", pops, 0);

      // Address NACK with a byte waiting: no pop.
      pl = '{8'h77};
      preload(pl);
      pops = 0; nack_at = 0;
      exp_bytes = '{8'h66};
      exp_done.push_back('{177, 1});
      start_txn(7'h33);
      wait_done();
      chk("pops_addr_nack", pops, 0);
      chk("nack_sticky", int'(nack), 1);

      // Next accepted start clears nack; the waiting byte is sent.
      pops = 0; nack_at = -1;
      exp_bytes = '{8'h66, 8'h77};
      exp_done.push_back('{323, 0});
      start_txn(7'h33);
      chk("nack_cleared", int'(nack), 0);
      wait_done();
      chk("pops_after_nack", pops, 1);

      // Data NACK on the first of three bytes.
      pl = '{8'h01, 8'h02, 8'h03};
      preload(pl);
      pops = 0; nack_at = 1;
      exp_bytes = '{8'h80, 8'h01};
`ifdef I2C_TX_NACK_FLUSH_EN
      exp_done.push_back('{326, 1});
`else
      exp_done.push_back('{322, 1});
`endif
      start_txn(7'h40);
      wait_done();
`ifdef I2C_TX_NACK_FLUSH_EN
      chk("pops_data_nack_flush", pops, 3);
      chk("fifo_left_flush", fifo_q.size(), 0);
      pops = 0; nack_at = -1;
      exp_bytes = '{8'h80};
      exp_done.push_back('{178, 0});
`else
      chk("pops_data_nack", pops, 1);
      chk("fifo_left", fifo_q.size(), 2);
      pops = 0; nack_at = -1;
      exp_bytes = '{8'h80, 8'h02, 8'h03};
      exp_done.push_back('{468, 0});
`endif
      start_txn(7'h40);
      wait_done();

      // Asynchronous reset during the third data bit.
      pl = '{8'hAA, 8'hBB};
      preload(pl);
      pops = 0; nack_at = -1;
      exp_bytes = '{8'h54};
      start_txn(7'h2A);
      repeat (199) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_scl", int'(scl), 1);
      chk("midrst_sda", int'(sda), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rinc", int'(rinc), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(negedge clk);
      chk("midrst_pops", pops, 1);
      chk("midrst_busy_after", int'(busy), 0);
      chk("midrst_bytes", exp_bytes.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
